// File: rtl/vga_seq_pkg.sv
// Shared types and defaults for the VGA pattern sequencer.
package vga_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_SWITCH = 2'd2
    } seq_state_t;

    localparam int PAT_RESET        = 0;
    localparam int DEF_HOLD_FRAMES  = 60;
    localparam int DEF_NUM_PATTERNS = 4;

endpackage

// File: rtl/vsync_edge_detect.sv
// Finds the falling edge of the active-low vsync and emits a registered
// frame_start pulse for boundaries the sequencer actually accepts.
module vsync_edge_detect (
    input  logic clk_25,
    input  logic rst_n,
    input  logic vsync,
    input  logic qualify,
    output logic fall,
    output logic frame_start
);

    logic vsync_q;

    assign fall = vsync_q & ~vsync;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            frame_start <= fall & qualify;
        end
    end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern sequencer: counts frames and advances the
// pattern index on hold expiry or manual step, committing only inside vsync.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | disabled; index, counters and handshake held at zero
// S_RUN    | counting frames, waiting for a boundary that needs a step
// S_SWITCH | one cycle after the boundary: commit next index, ack request
module vga_pattern_sequencer
    import vga_seq_pkg::*;
#(
    parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int PAT_W        = 2,
    parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
    parameter int FCNT_W       = 16
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              enable,
    input  logic              auto_en,
    input  logic              step_req,
    output logic              step_ack,
    output logic [PAT_W-1:0]  pattern_sel,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(NUM_PATTERNS - 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PAT_W-1:0]  pat_next;
    logic              pending;
    logic              fall;
    logic              count_ok;
    logic              expiry;
    logic              take_step;

    // Only boundaries seen while running count; this also keeps frame_start quiet in idle.
    assign count_ok = enable && (state == S_RUN);
    assign pat_next = (pattern_sel == PAT_LAST) ? PAT_W'(PAT_RESET) : pattern_sel + 1'b1;

    vsync_edge_detect u_edge (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .qualify     (count_ok),
        .fall        (fall),
        .frame_start (frame_start)
    );

    always_comb begin
        state_nxt = state;
        expiry    = auto_en && (hold_cnt == HOLD_LAST);
        take_step = fall && (pending || expiry);
        case (state)
            S_IDLE:   if (enable) state_nxt = S_RUN;
            S_RUN:    if (take_step) state_nxt = S_SWITCH;
            S_SWITCH: state_nxt = S_RUN;
            default:  state_nxt = S_IDLE;
        endcase
        if (!enable) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            pattern_sel <= PAT_W'(PAT_RESET);
            frame_count <= '0;
            hold_cnt    <= '0;
            pending     <= 1'b0;
            step_ack    <= 1'b0;
        end else if (!enable || state == S_IDLE) begin
            pattern_sel <= PAT_W'(PAT_RESET);
            frame_count <= '0;
            hold_cnt    <= '0;
            pending     <= 1'b0;
            step_ack    <= 1'b0;
        end else begin
            if (step_ack && !step_req) step_ack <= 1'b0;
            if (step_req && !step_ack && !pending) pending <= 1'b1;
            case (state)
                S_RUN: begin
                    if (fall) begin
                        frame_count <= frame_count + 1'b1;
                        if (!take_step) hold_cnt <= auto_en ? hold_cnt + 1'b1 : '0;
                    end
                end
                S_SWITCH: begin
                    pattern_sel <= pat_next;
                    hold_cnt    <= '0;
                    // A coincident auto expiry still yields a single step and ack.
                    if (pending) begin
                        step_ack <= 1'b1;
                        pending  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: two parameterisations driven by shared
// stimulus, each checked every cycle against a frame-level reference model.
module tb_vga_pattern_sequencer;

    logic        clk_25 = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        enable;
    logic        auto_en;
    logic        step_req;
    logic        ack_a, ack_b, fs_a, fs_b;
    logic [1:0]  pat_a, pat_b;
    logic [15:0] fc_a, fc_b;

    int checks  = 0;
    int errors  = 0;
    int fs_seen = 0;
    bit cmp_on  = 1'b0;

    int exp_a[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int exp_b[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

    always #20 clk_25 = ~clk_25;

    vga_pattern_sequencer #(.NUM_PATTERNS(4), .PAT_W(2), .HOLD_FRAMES(2), .FCNT_W(16)) dut_a (
        .clk_25(clk_25), .rst_n(rst_n), .vsync(vsync), .enable(enable), .auto_en(auto_en),
        .step_req(step_req), .step_ack(ack_a), .pattern_sel(pat_a), .frame_start(fs_a),
        .frame_count(fc_a)
    );

    vga_pattern_sequencer #(.NUM_PATTERNS(3), .PAT_W(2), .HOLD_FRAMES(3), .FCNT_W(16)) dut_b (
        .clk_25(clk_25), .rst_n(rst_n), .vsync(vsync), .enable(enable), .auto_en(auto_en),
        .step_req(step_req), .step_ack(ack_b), .pattern_sel(pat_b), .frame_start(fs_b),
        .frame_count(fc_b)
    );

    // Reference model: "active" = sequencer running, "commit_due" = a step was
    // decided at the last boundary and becomes visible after one more cycle.
    typedef struct {
        bit vq;
        bit active;
        bit commit_due;
        int pat;
        int fc;
        int hold;
        bit pending;
        bit ack;
        bit fs;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.vq = 1'b1; m.active = 1'b0; m.commit_due = 1'b0;
        m.pat = 0; m.fc = 0; m.hold = 0;
        m.pending = 1'b0; m.ack = 1'b0; m.fs = 1'b0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit vs, bit en, bit au, bit rq, int num, int hf);
        mdl_t n;
        bit   boundary;
        n        = m;
        boundary = m.vq && !vs;
        n.vq     = vs;
        n.fs     = 1'b0;
        if (!en || !m.active) begin
            n.active = en; n.commit_due = 1'b0;
            n.pat = 0; n.fc = 0; n.hold = 0;
            n.pending = 1'b0; n.ack = 1'b0;
            return n;
        end
        if (m.ack && !rq) n.ack = 1'b0;
        if (rq && !m.ack && !m.pending) n.pending = 1'b1;
        if (m.commit_due) begin
            n.commit_due = 1'b0;
            n.pat        = (m.pat + 1) % num;
            n.hold       = 0;
            if (m.pending) begin
                n.ack     = 1'b1;
                n.pending = 1'b0;
            end
        end else if (boundary) begin
            n.fc = (m.fc + 1) % 65536;
            n.fs = 1'b1;
            if (m.pending || (au && m.hold == hf - 1)) n.commit_due = 1'b1;
            else n.hold = au ? m.hold + 1 : 0;
        end
        return n;
    endfunction

    always @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = mstep(ma, vsync, enable, auto_en, step_req, 4, 2);
            mb = mstep(mb, vsync, enable, auto_en, step_req, 3, 3);
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_25) begin
        if (cmp_on) begin
            check("a_pattern", int'(pat_a), ma.pat);
            check("a_count",   int'(fc_a),  ma.fc);
            check("a_fstart",  int'(fs_a),  int'(ma.fs));
            check("a_ack",     int'(ack_a), int'(ma.ack));
            check("b_pattern", int'(pat_b), mb.pat);
            check("b_count",   int'(fc_b),  mb.fc);
            check("b_fstart",  int'(fs_b),  int'(mb.fs));
            check("b_ack",     int'(ack_b), int'(mb.ack));
            check("b_in_range", int'(pat_b < 2'd3), 1);
        end
    end

    always @(negedge clk_25) if (fs_a || fs_b) fs_seen++;

    task automatic active_part(int len, int req_at);
        vsync = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i == req_at) step_req = 1'b1;
            @(negedge clk_25);
        end
    endtask

    task automatic sync_part(int len);
        vsync = 1'b0;
        for (int i = 0; i < len; i++) @(negedge clk_25);
    endtask

    task automatic rtick();
        if (!step_req && !ack_a && $urandom_range(0, 15) == 0) step_req = 1'b1;
        else if (step_req && ack_a && $urandom_range(0, 3) == 0) step_req = 1'b0;
        if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
        else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
        @(negedge clk_25);
    endtask

    task automatic rand_frame();
        auto_en = 1'($urandom_range(0, 1));
        vsync   = 1'b1;
        for (int i = 0; i < int'($urandom_range(4, 16)); i++) rtick();
        vsync = 1'b0;
        for (int i = 0; i < int'($urandom_range(2, 6)); i++) rtick();
    endtask

    initial begin
        int  base_a;
        int  base_b;
        int  fs0;
        bit  found;
        rst_n = 1'b0; vsync = 1'b1; enable = 1'b0; auto_en = 1'b0; step_req = 1'b0;
        cmp_on = 1'b1;
        @(negedge clk_25);
        check("rst_pat_a", int'(pat_a), 0);
        check("rst_fc_a",  int'(fc_a), 0);
        check("rst_ack_a", int'(ack_a), 0);
        check("rst_fs_a",  int'(fs_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_25);

        // Auto mode: HOLD 2 on dut_a, HOLD 3 / three patterns on dut_b
        enable = 1'b1; auto_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            active_part($urandom_range(6, 14), -1);
            check("auto_seq_a", int'(pat_a), exp_a[k]);
            check("auto_seq_b", int'(pat_b), exp_b[k]);
            sync_part($urandom_range(2, 5));
        end
        check("auto_fc9_a", int'(fc_a), 9);
        check("wrap_b", int'(pat_b), 0);

        // Manual step with request raised mid-frame, then held for 3 frames
        auto_en = 1'b0;
        base_a = ma.pat; base_b = mb.pat;
        active_part(12, 5);
        check("man_wait_a", int'(pat_a), base_a);
        check("man_wait_ack", int'(ack_a), 0);
        sync_part(4);
        check("man_step_a", int'(pat_a), (base_a + 1) % 4);
        check("man_step_b", int'(pat_b), (base_b + 1) % 3);
        check("man_ack_a", int'(ack_a), 1);
        for (int k = 0; k < 3; k++) begin
            active_part(10, -1);
            sync_part(3);
        end
        check("man_once_a", int'(pat_a), (base_a + 1) % 4);
        check("man_ack_held", int'(ack_a), 1);
        step_req = 1'b0;
        @(negedge clk_25);
        check("man_ack_drop", int'(ack_a), 0);

        // Manual request landing on the same boundary as dut_b's expiry
        auto_en = 1'b1;
        base_b = mb.pat;
        for (int k = 0; k < 2; k++) begin
            active_part(8, -1);
            sync_part(3);
        end
        check("sim_pre_b", int'(pat_b), base_b);
        active_part(10, 4);
        sync_part(4);
        check("sim_step_b", int'(pat_b), (base_b + 1) % 3);
        check("sim_ack_b", int'(ack_b), 1);
        step_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            active_part(8, -1);
            sync_part(3);
            check("sim_next_b", int'(pat_b), (k < 2) ? (base_b + 1) % 3 : (base_b + 2) % 3);
        end

        // Drop enable while dut_a shows pattern 2 with ack high
        auto_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            active_part(8, 3);
            sync_part(3);
            if (ma.pat == 2 && ma.ack) found = 1'b1;
            else begin
                step_req = 1'b0;
                repeat (2) @(negedge clk_25);
            end
        end
        check("dis_setup", int'(found), 1);
        check("dis_pre_pat", int'(pat_a), 2);
        enable = 1'b0;
        @(negedge clk_25);
        check("dis_pat_a", int'(pat_a), 0);
        check("dis_ack_a", int'(ack_a), 0);
        check("dis_fc_a",  int'(fc_a), 0);
        step_req = 1'b0;
        fs0 = fs_seen;
        for (int k = 0; k < 2; k++) begin
            active_part(8, -1);
            sync_part(3);
        end
        check("dis_no_fs", fs_seen - fs0, 0);

        // Randomised traffic
        enable = 1'b1;
        for (int k = 0; k < 30; k++) rand_frame();

        // Asynchronous reset between clock edges
        enable = 1'b1; auto_en = 1'b1; step_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            active_part(8, -1);
            sync_part(3);
        end
        check("pre_rst_fc", int'(fc_a != 16'd0), 1);
        @(posedge clk_25);
        #7 rst_n = 1'b0;
        #2;
        check("arst_pat_a", int'(pat_a), 0);
        check("arst_fc_a",  int'(fc_a), 0);
        check("arst_ack_a", int'(ack_a), 0);
        check("arst_fs_a",  int'(fs_a), 0);
        check("arst_fc_b",  int'(fc_b), 0);
        #5 rst_n = 1'b1;
        @(negedge clk_25);
        for (int k = 0; k < 3; k++) begin
            active_part(8, -1);
            sync_part(3);
        end
        check("post_rst_fc", int'(fc_a), 3);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
